// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - fixed-priority interrupt controller with ID-read ack and EOI handshake
//
// Ports:
//   clk        - single clock, all state on rising edge
//   rst        - synchronous active-high reset
//   irq_in     - raw asynchronous interrupt lines, active-high
//   ioAddress  - CPU I/O address; registers live at BASE..BASE+4
//   ioIn       - CPU write data
//   ioWriteEn  - one-cycle write strobe
//   ioReadEn   - one-cycle read strobe
//   ioOut      - registered read data, 0 in any cycle after a non-read
//   cpu_irq    - request to the CPU, high while in REQ
//
// Registers (offset from BASE):
//   +0 ENABLE RW, +1 PENDING R/W1C, +2 EDGE_SEL RW (1 = rising edge),
//   +3 ID R {active, 4'b0, id}, +4 EOI W

module irq_ctrl #(
    parameter int          NUM_SRC = 8,
    parameter logic [15:0] BASE    = 16'h1040
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [15:0]        ioAddress,
    input  logic [7:0]         ioIn,
    input  logic               ioWriteEn,
    input  logic               ioReadEn,
    output logic [7:0]         ioOut,
    output logic               cpu_irq
);

    localparam logic [15:0] ADDR_ENABLE  = BASE;
    localparam logic [15:0] ADDR_PENDING = BASE + 16'd1;
    localparam logic [15:0] ADDR_EDGE    = BASE + 16'd2;
    localparam logic [15:0] ADDR_ID      = BASE + 16'd3;
    localparam logic [15:0] ADDR_EOI     = BASE + 16'd4;

    // Registers are kept 8 bits wide; bits above NUM_SRC are forced to 0.
    localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [7:0] enable_reg;
    logic [7:0] pending_reg;
    logic [7:0] edge_sel_reg;
    logic [7:0] sync_s1;
    logic [7:0] sync_s2;
    logic [7:0] sync_prev;
    logic [1:0] state;
    logic [2:0] id_reg;

    logic [7:0] irq_ext;
    logic [7:0] req_vec;
    logic       any_req;
    logic [2:0] win_id;
    logic       wr_enable, wr_pending, wr_edge, wr_eoi, rd_id;
    logic       ack;
    logic [7:0] clr_mask;
    logic [7:0] rise;
    logic [7:0] pending_next;
    logic [7:0] rd_data;

    assign irq_ext = 8'(irq_in);

    assign wr_enable  = ioWriteEn && (ioAddress == ADDR_ENABLE);
    assign wr_pending = ioWriteEn && (ioAddress == ADDR_PENDING);
    assign wr_edge    = ioWriteEn && (ioAddress == ADDR_EDGE);
    assign wr_eoi     = ioWriteEn && (ioAddress == ADDR_EOI);
    assign rd_id      = ioReadEn  && (ioAddress == ADDR_ID);

    // The ID read is the acknowledge only while a request is outstanding.
    assign ack = rd_id && (state == ST_REQ);

    assign req_vec = pending_reg & enable_reg & SRC_MASK;
    assign any_req = |req_vec;

    // Lowest index wins; scanning downward leaves the lowest set bit last.
    always_comb begin
        win_id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_vec[i]) begin
                win_id = 3'(i);
            end
        end
    end

    // Edge bits: clear (W1C or ack) first, then OR in a new rise so a
    // same-cycle set wins. Level bits simply follow the synchronized pin.
    always_comb begin
        clr_mask = 8'd0;
        if (wr_pending) begin
            clr_mask = clr_mask | ioIn;
        end
        if (ack) begin
            clr_mask = clr_mask | (8'd1 << id_reg);
        end
        rise         = sync_s2 & ~sync_prev;
        pending_next = ((edge_sel_reg & ((pending_reg & ~clr_mask) | rise)) |
                        (~edge_sel_reg & sync_s2)) & SRC_MASK;
    end

    always_comb begin
        rd_data = 8'd0;
        if (ioReadEn) begin
            case (ioAddress)
                ADDR_ENABLE:  rd_data = enable_reg;
                ADDR_PENDING: rd_data = pending_reg;
                ADDR_EDGE:    rd_data = edge_sel_reg;
                ADDR_ID:      rd_data = {(state == ST_REQ), 4'b0000, id_reg};
                default:      rd_data = 8'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_reg   <= 8'd0;
            pending_reg  <= 8'd0;
            edge_sel_reg <= 8'd0;
            sync_s1      <= 8'd0;
            sync_s2      <= 8'd0;
            sync_prev    <= 8'd0;
            state        <= ST_IDLE;
            id_reg       <= 3'd0;
            ioOut        <= 8'd0;
        end else begin
            sync_s1   <= irq_ext & SRC_MASK;
            sync_s2   <= sync_s1;
            sync_prev <= sync_s2;

            pending_reg <= pending_next;
            ioOut       <= rd_data;

            if (wr_enable) begin
                enable_reg <= ioIn & SRC_MASK;
            end
            if (wr_edge) begin
                edge_sel_reg <= ioIn & SRC_MASK;
            end

            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state  <= ST_REQ;
                        id_reg <= win_id;
                    end
                end
                ST_REQ: begin
                    if (ack) begin
                        state <= ST_SERVICE;
                    end else if (!any_req) begin
                        // Request withdrawn before the CPU acknowledged it.
                        state <= ST_IDLE;
                    end else begin
                        id_reg <= win_id;
                    end
                end
                ST_SERVICE: begin
                    if (wr_eoi) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_irq = (state == ST_REQ);

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl

module tb_irq_ctrl;

    localparam logic [15:0] BASE = 16'h1040;
    localparam logic [15:0] A_ENABLE  = BASE;
    localparam logic [15:0] A_PENDING = BASE + 16'd1;
    localparam logic [15:0] A_EDGE    = BASE + 16'd2;
    localparam logic [15:0] A_ID      = BASE + 16'd3;
    localparam logic [15:0] A_EOI     = BASE + 16'd4;

    logic        clk;
    logic        rst;
    logic [7:0]  irq_in;
    logic [15:0] ioAddress;
    logic [7:0]  ioIn;
    logic        ioWriteEn;
    logic        ioReadEn;
    logic [7:0]  ioOut;
    logic        cpu_irq;

    int vectors;
    int miscompares;
    logic [7:0] d;

    irq_ctrl #(.NUM_SRC(8), .BASE(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .ioAddress (ioAddress),
        .ioIn      (ioIn),
        .ioWriteEn (ioWriteEn),
        .ioReadEn  (ioReadEn),
        .ioOut     (ioOut),
        .cpu_irq   (cpu_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] v);
        ioAddress = a;
        ioIn      = v;
        ioWriteEn = 1'b1;
        tick();
        ioWriteEn = 1'b0;
        ioIn      = 8'd0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] v);
        ioAddress = a;
        ioReadEn  = 1'b1;
        tick();
        ioReadEn  = 1'b0;
        v = ioOut;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        irq_in    = 8'hFF;
        ioAddress = 16'd0;
        ioIn      = 8'd0;
        ioWriteEn = 1'b0;
        ioReadEn  = 1'b0;

        // Reset with all lines high
        tick();
        tick();
        check("rst_cpu_irq", {7'd0, cpu_irq}, 8'h00);
        check("rst_ioOut", ioOut, 8'h00);
        rst    = 1'b0;
        irq_in = 8'h00;
        rd(A_ENABLE, d);  check("rst_enable", d, 8'h00);
        rd(A_PENDING, d); check("rst_pending", d, 8'h00);
        rd(A_EDGE, d);    check("rst_edge_sel", d, 8'h00);
        rd(A_ID, d);      check("rst_id", d, 8'h00);
        tick();
        check("idle_ioOut_zero", ioOut, 8'h00);

        // Single edge source 3
        wr(A_ENABLE, 8'h08);
        wr(A_EDGE, 8'h08);
        rd(A_ENABLE, d); check("enable_rb", d, 8'h08);
        irq_in = 8'h08;
        tick();
        irq_in = 8'h00;
        tick();
        tick();
        check("edge_lat_e3", {7'd0, cpu_irq}, 8'h00);
        tick();
        check("edge_lat_e4", {7'd0, cpu_irq}, 8'h01);
        rd(A_ID, d);
        check("ack_id3", d, 8'h83);
        check("ack_drop", {7'd0, cpu_irq}, 8'h00);
        rd(A_PENDING, d); check("ack_clears_pending", d, 8'h00);
        rd(A_ID, d);      check("id_in_service", d, 8'h03);
        wr(A_EOI, 8'h5A);
        tick();
        check("eoi_idle", {7'd0, cpu_irq}, 8'h00);

        // Priority: sources 5 and 2 together
        wr(A_ENABLE, 8'hFF);
        wr(A_EDGE, 8'hFF);
        irq_in = 8'h24;
        tick();
        irq_in = 8'h00;
        tick();
        tick();
        tick();
        check("prio_req", {7'd0, cpu_irq}, 8'h01);
        rd(A_ID, d);      check("prio_id2", d, 8'h82);
        rd(A_PENDING, d); check("prio_pending", d, 8'h20);
        wr(A_EOI, 8'h00);
        check("prio_gap", {7'd0, cpu_irq}, 8'h00);
        tick();
        check("prio_reassert", {7'd0, cpu_irq}, 8'h01);
        rd(A_ID, d);      check("prio_id5", d, 8'h85);
        wr(A_EOI, 8'h00);
        tick();
        check("prio_done", {7'd0, cpu_irq}, 8'h00);

        // Level mode on source 0
        wr(A_EDGE, 8'h00);
        wr(A_ENABLE, 8'h01);
        irq_in = 8'h01;
        tick();
        tick();
        tick();
        tick();
        check("lvl_req", {7'd0, cpu_irq}, 8'h01);
        wr(A_PENDING, 8'h01);
        rd(A_PENDING, d); check("lvl_w1c_nop", d, 8'h01);
        irq_in = 8'h00;
        tick();
        tick();
        tick();
        check("lvl_still_req", {7'd0, cpu_irq}, 8'h01);
        tick();
        check("lvl_withdrawn", {7'd0, cpu_irq}, 8'h00);
        rd(A_ID, d); check("lvl_id_idle", d, 8'h00);

        // Collision of W1C and a new rising edge on source 1
        wr(A_ENABLE, 8'h00);
        wr(A_EDGE, 8'h02);
        irq_in = 8'h02;
        tick();
        tick();
        wr(A_PENDING, 8'h02);
        irq_in = 8'h00;
        rd(A_PENDING, d); check("collision_set_wins", d, 8'h02);
        wr(A_PENDING, 8'h02);
        rd(A_PENDING, d); check("w1c_clears", d, 8'h00);

        // Address decode
        wr(BASE + 16'd5, 8'hFF);
        wr(BASE - 16'd1, 8'hFF);
        rd(BASE - 16'd1, d); check("decode_ioOut", d, 8'h00);
        rd(A_ENABLE, d);     check("decode_enable", d, 8'h00);
        rd(A_EDGE, d);       check("decode_edge", d, 8'h02);
        rd(A_PENDING, d);    check("decode_pending", d, 8'h00);
        check("decode_cpu_irq", {7'd0, cpu_irq}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
